// File: rtl/oled_text_writer_if.sv
// Bus bundle for oled_text_writer: ASCII byte stream in, font ROM read port, framebuffer write port.
// slave = renderer side, master = the environment that feeds it.
interface oled_text_writer_if;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_data;
    logic [9:0] font_addr;
    logic [7:0] font_data;
    logic       write_en;
    logic [9:0] write_addr;
    logic [7:0] write_data;

    modport slave (
        input  char_valid, char_data, font_data,
        output char_ready, font_addr, write_en, write_addr, write_data
    );

    modport master (
        output char_valid, char_data, font_data,
        input  char_ready, font_addr, write_en, write_addr, write_data
    );
endinterface

// File: rtl/oled_text_writer.sv
// Renders an ASCII stream into a 16x8 text grid of a 128x64 SSD1306 framebuffer via an external font ROM.
// Optional feature macro: OLED_TEXT_INVERT_EN adds the invert input (glyph data XOR'ed per character).
module oled_text_writer #(
    parameter int unsigned FONT_LAT = 1,
    parameter logic [7:0]  CLR_BYTE = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    oled_text_writer_if.slave        bus,
    output logic                     busy,
    output logic [3:0]               cur_col,
    output logic [2:0]               cur_row
`ifdef OLED_TEXT_INVERT_EN
    ,
    input  logic                     invert
`endif
);
    localparam int unsigned STEP_W     = 4;
    localparam int unsigned GLYPH_COLS = 8;
    localparam int unsigned LAST_STEP  = GLYPH_COLS + FONT_LAT;
    localparam logic [9:0]  LAST_ADDR  = 10'd1023;

    typedef enum logic [1:0] {IDLE, GLYPH, NEWLINE, CLEAR} state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [9:0]          font_addr_q, font_addr_d;
    logic                write_en_q, write_en_d;
    logic [9:0]          write_addr_q, write_addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                wr_font_q, wr_font_d;
    logic [6:0]          idx_q, idx_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [3:0]          col_q, col_d;
    logic [2:0]          row_q, row_d;
    logic [7:0]          glyph_data_c;
    logic [7:0]          wdata_c;
    logic                transfer_c;

    // Printable codes map to glyph index code-0x20; everything else shows as '?'
    function automatic logic [6:0] glyph_idx(input logic [7:0] code);
        if (code >= 8'h20 && code <= 8'h7E) return 7'(code - 8'h20);
        else                                return 7'h1F;
    endfunction

`ifdef OLED_TEXT_INVERT_EN
    logic inv_q, inv_d;
    assign glyph_data_c = bus.font_data ^ {8{inv_q}};
`else
    assign glyph_data_c = bus.font_data;
`endif

    // ROM data streams straight through while a glyph write is active, else the last byte is held
    assign wdata_c    = wr_font_q ? glyph_data_c : wdata_q;
    assign transfer_c = bus.char_valid & ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            font_addr_q  <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            wdata_q      <= '0;
            wr_font_q    <= 1'b0;
            idx_q        <= '0;
            step_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
`ifdef OLED_TEXT_INVERT_EN
            inv_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            font_addr_q  <= font_addr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            wdata_q      <= wdata_d;
            wr_font_q    <= wr_font_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            col_q        <= col_d;
            row_q        <= row_d;
`ifdef OLED_TEXT_INVERT_EN
            inv_q        <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        font_addr_d  = font_addr_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        wdata_d      = wdata_c;
        wr_font_d    = 1'b0;
        idx_d        = idx_q;
        step_d       = step_q;
        col_d        = col_q;
        row_d        = row_q;
`ifdef OLED_TEXT_INVERT_EN
        inv_d        = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer_c) begin
                    case (bus.char_data)
                        8'h0A: state_d = NEWLINE;
                        8'h0C: begin
                            state_d      = CLEAR;
                            write_en_d   = 1'b1;
                            write_addr_d = '0;
                            wdata_d      = CLR_BYTE;
                        end
                        default: begin
                            state_d     = GLYPH;
                            idx_d       = glyph_idx(bus.char_data);
                            font_addr_d = {idx_d, 3'd0};
                            step_d      = STEP_W'(1);
`ifdef OLED_TEXT_INVERT_EN
                            inv_d       = invert;
`endif
                        end
                    endcase
                end
            end
            GLYPH: begin
                // step counts cycles since transfer; writes lag the ROM address by FONT_LAT
                step_d = step_q + STEP_W'(1);
                if (step_q < STEP_W'(GLYPH_COLS))
                    font_addr_d = {idx_q, step_q[2:0]};
                if (step_q >= STEP_W'(FONT_LAT) && step_q < STEP_W'(LAST_STEP)) begin
                    write_en_d   = 1'b1;
                    wr_font_d    = 1'b1;
                    write_addr_d = {row_q, col_q, 3'(step_q - STEP_W'(FONT_LAT))};
                end
                if (step_q == STEP_W'(LAST_STEP)) begin
                    state_d        = IDLE;
                    {row_d, col_d} = {row_q, col_q} + 7'd1;
                end
            end
            NEWLINE: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = row_q + 3'd1;
            end
            CLEAR: begin
                if (write_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    write_en_d   = 1'b1;
                    write_addr_d = write_addr_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    assign bus.char_ready = ready_q;
    assign bus.font_addr  = font_addr_q;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = wdata_c;
    assign busy           = ~ready_q;
    assign cur_col        = col_q;
    assign cur_row        = row_q;
endmodule

// File: tb/tb_oled_text_writer.sv
// Directed bench for oled_text_writer: glyph timing, cursor wrap, newline, clear, '?' fallback, resets.
module tb_oled_text_writer;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] cur_col;
    logic [2:0] cur_row;
`ifdef OLED_TEXT_INVERT_EN
    logic       invert;
`endif
    int checks = 0;
    int errors = 0;
    int bad;

    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];

    oled_text_writer_if bus ();

    oled_text_writer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .cur_col (cur_col),
        .cur_row (cur_row)
`ifdef OLED_TEXT_INVERT_EN
        ,
        .invert  (invert)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h3C;
    endfunction

    // Font ROM with one cycle of read latency
    always @(posedge clk) bus.font_data <= rom_f(bus.font_addr);

    // Framebuffer write log
    always @(negedge clk) begin
        if (bus.write_en === 1'b1) begin
            wa_q.push_back(bus.write_addr);
            wd_q.push_back(bus.write_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (bus.char_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(bus.char_ready), 32'd1);
    endtask

    // Leaves the bench at cycle T1 (one cycle after the transfer edge)
    task automatic send(input logic [7:0] c);
        wait_ready(2000);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        tick();
        bus.char_valid = 1'b0;
    endtask

    task automatic send_wait(input logic [7:0] c);
        send(c);
        wait_ready(2000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
`ifdef OLED_TEXT_INVERT_EN
        invert         = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready", 32'(bus.char_ready), 32'd1);
        chk("rst_wen", 32'(bus.write_en), 32'd0);
        chk("rst_waddr", 32'(bus.write_addr), 32'd0);
        chk("rst_wdata", 32'(bus.write_data), 32'd0);
        chk("rst_faddr", 32'(bus.font_addr), 32'd0);
        chk("rst_cursor", {cur_row, cur_col}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // 'A': address, write and ready timing cycle by cycle
        send(8'h41);
        chk("a_busy", 32'(busy), 32'd1);
        for (int n = 1; n <= 9; n++) begin
            if (n <= 8) chk("a_faddr", 32'(bus.font_addr), 32'(10'h108 + n - 1));
            if (n >= 2) begin
                chk("a_wen", 32'(bus.write_en), 32'd1);
                chk("a_waddr", 32'(bus.write_addr), 32'(n - 2));
                chk("a_wdata", 32'(bus.write_data), 32'(rom_f(10'(10'h108 + n - 2))));
            end else begin
                chk("a_wen_t1", 32'(bus.write_en), 32'd0);
            end
            tick();
        end
        chk("a_ready_t10", 32'(bus.char_ready), 32'd1);
        chk("a_wen_t10", 32'(bus.write_en), 32'd0);
        chk("a_cursor", {cur_row, cur_col}, {3'd0, 4'd1});
        chk("a_hold_waddr", 32'(bus.write_addr), 32'd7);
        chk("a_hold_wdata", 32'(bus.write_data), 32'(rom_f(10'h10F)));

        // Reset in the middle of a glyph
        send(8'h42);
        repeat (4) tick();
        chk("mg_pre_wen", 32'(bus.write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mg_wen", 32'(bus.write_en), 32'd0);
        chk("mg_cursor", {cur_row, cur_col}, 32'd0);
        chk("mg_ready", 32'(bus.char_ready), 32'd1);
        chk("mg_faddr", 32'(bus.font_addr), 32'd0);
        tick();
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        repeat (12) tick();
        chk("mg_no_writes", wa_q.size(), 32'd0);

        // 17 characters: the 17th lands on row 1
        for (int i = 0; i < 16; i++) send_wait(8'(8'h30 + i));
        wa_q.delete();
        wd_q.delete();
        send_wait(8'h61);
        chk("c17_count", wa_q.size(), 32'd8);
        chk("c17_first", 32'(wa_q[0]), 32'd128);
        chk("c17_last", 32'(wa_q[7]), 32'd135);
        chk("c17_data", 32'(wd_q[3]), 32'(rom_f(10'h20B)));
        chk("c17_cursor", {cur_row, cur_col}, {3'd1, 4'd1});

        // Bottom-right corner and wrap back to the origin
        do_reset();
        repeat (7) send_wait(8'h0A);
        repeat (15) send_wait(8'h2E);
        chk("wr_pre_cursor", {cur_row, cur_col}, {3'd7, 4'd15});
        wa_q.delete();
        wd_q.delete();
        send_wait(8'h5A);
        chk("wr_count", wa_q.size(), 32'd8);
        chk("wr_first", 32'(wa_q[0]), 32'd1016);
        chk("wr_last", 32'(wa_q[7]), 32'd1023);
        chk("wr_cursor", {cur_row, cur_col}, 32'd0);

        // Newline from (col 5, row 2)
        repeat (2) send_wait(8'h0A);
        repeat (5) send_wait(8'h21);
        chk("nl_pre_cursor", {cur_row, cur_col}, {3'd2, 4'd5});
        wa_q.delete();
        wd_q.delete();
        send(8'h0A);
        chk("nl_wen", 32'(bus.write_en), 32'd0);
        chk("nl_busy", 32'(busy), 32'd1);
        tick();
        chk("nl_cursor", {cur_row, cur_col}, {3'd3, 4'd0});
        chk("nl_ready", 32'(bus.char_ready), 32'd1);
        chk("nl_no_writes", wa_q.size(), 32'd0);

        // Non-printable code held valid through busy: one '?' glyph only
        wait_ready(50);
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h07;
        tick();
        chk("q_faddr", 32'(bus.font_addr), 32'h0F8);
        wait_ready(50);
        bus.char_valid = 1'b0;
        repeat (12) tick();
        chk("q_count", wa_q.size(), 32'd8);
        chk("q_first", 32'(wa_q[0]), 32'd384);
        chk("q_data0", 32'(wd_q[0]), 32'(rom_f(10'h0F8)));
        chk("q_data7", 32'(wd_q[7]), 32'(rom_f(10'h0FF)));
        chk("q_cursor", {cur_row, cur_col}, {3'd3, 4'd1});

        // Clear screen
        wa_q.delete();
        wd_q.delete();
        send(8'h0C);
        wait_ready(1100);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 10'(i) || wd_q[i] !== 8'h00) bad++;
        chk("clr_count", wa_q.size(), 32'd1024);
        chk("clr_bad", 32'(bad), 32'd0);
        chk("clr_cursor", {cur_row, cur_col}, 32'd0);
        chk("clr_last_addr", 32'(bus.write_addr), 32'd1023);

        // Reset in the middle of a clear, then normal operation resumes
        send_wait(8'h41);
        send(8'h0C);
        repeat (300) tick();
        chk("mc_pre_wen", 32'(bus.write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mc_wen", 32'(bus.write_en), 32'd0);
        chk("mc_waddr", 32'(bus.write_addr), 32'd0);
        chk("mc_cursor", {cur_row, cur_col}, 32'd0);
        tick();
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        repeat (20) tick();
        chk("mc_no_writes", wa_q.size(), 32'd0);
        send_wait(8'h41);
        chk("mc_after_count", wa_q.size(), 32'd8);
        chk("mc_after_first", 32'(wa_q[0]), 32'd0);

`ifdef OLED_TEXT_INVERT_EN
        // Inverted glyph; clear stays unaffected
        do_reset();
        invert = 1'b1;
        send(8'h41);
        invert = 1'b0;
        wait_ready(50);
        chk("inv_count", wa_q.size(), 32'd8);
        chk("inv_data0", 32'(wd_q[0]), 32'(~rom_f(10'h108)));
        chk("inv_data7", 32'(wd_q[7]), 32'(~rom_f(10'h10F)));
        wa_q.delete();
        wd_q.delete();
        invert = 1'b1;
        send(8'h0C);
        wait_ready(1100);
        repeat (3) tick();
        chk("inv_clr_data", 32'(wd_q[5]), 32'd0);
        invert = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
